fir_mac_scheduler: RTL and testbench

Time-multiplexed FIR controller that shares one external combinational fixed-point MAC across TAPS coefficients.
- Accepts one sample per transaction and shifts it into an internal delay line.
- Each cycle, drives the MAC operands with sample, coefficient and running sum, and accumulates the MAC result.
- Emits one filtered word per sample.
- Sits between the sample source and the shared MAC datapath; owns the delay line and coefficient store.

---
 rtl/fir_sched_pkg.sv | 23 ++
 rtl/fir_delay_line.sv | 25 ++
 rtl/fir_mac_scheduler.sv | 108 ++++++++++
 tb/tb_fir_mac_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and Q-format helpers for the
// time-multiplexed FIR MAC scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  function automatic int tapWidth(input int taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

  function automatic longint qOne(input int wl, input int ip);
    return longint'(1) << (wl - ip);
  endfunction

  function automatic longint qHalf(input int wl, input int ip);
    return qOne(wl, ip) >> 1;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register; entry 0
// holds the newest word.
module fir_delay_line #(
  parameter int WORD_LENGTH = 16,
  parameter int TAPS        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  shiftEn,
  input  logic [WORD_LENGTH-1:0]                din,
  output logic [TAPS-1:0][WORD_LENGTH-1:0]      taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (shiftEn) begin
      taps[0] <= din;
      for (int i = 1; i < TAPS; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR controller sharing one external MAC
// across all taps, one tap per cycle.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int INTEGER_PART = 2,
  parameter int TAPS         = 4,
  localparam int TW          = tapWidth(TAPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [WORD_LENGTH-1:0] sample_in,
  output logic                   sample_ready,
  input  logic                   coef_we,
  input  logic [TW-1:0]          coef_addr,
  input  logic [WORD_LENGTH-1:0] coef_data,
  output logic [WORD_LENGTH-1:0] mac_a,
  output logic [WORD_LENGTH-1:0] mac_b,
  output logic [WORD_LENGTH-1:0] mac_c,
  input  logic [WORD_LENGTH-1:0] mac_d,
  output logic [WORD_LENGTH-1:0] result,
  output logic                   result_valid,
  output logic                   busy
);

  if (TAPS < 2 || INTEGER_PART >= WORD_LENGTH) begin : gBadCfg
    $error("fir_mac_scheduler: bad TAPS/INTEGER_PART");
  end

  state_t                        state;
  logic [TW-1:0]                 tap;
  logic [WORD_LENGTH-1:0]        acc;
  logic [TAPS-1:0][WORD_LENGTH-1:0] x;
  logic [WORD_LENGTH-1:0]        coef [TAPS];
  logic                          accept;
  logic                          lastTap;
  logic                          coefWrOk;

  assign accept   = (state == IDLE) && sample_valid;
  assign lastTap  = (tap == TW'(TAPS - 1));
  assign coefWrOk = (state == IDLE) && coef_we
                    && (int'(coef_addr) < TAPS);

  fir_delay_line #(
    .WORD_LENGTH (WORD_LENGTH),
    .TAPS        (TAPS)
  ) uDelay (
    .clk     (clk),
    .rst_n   (reset),
    .shiftEn (accept),
    .din     (sample_in),
    .taps    (x)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tap    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= mac_d;
          tap <= tap + 1'b1;
          if (lastTap) begin
            result <= mac_d;
            state  <= DONE;
          end
        end
        DONE: begin
          tap   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store is frozen outside IDLE so a result never mixes coefficient sets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (coefWrOk) begin
      coef[coef_addr] <= coef_data;
    end
  end

  assign mac_a = (state == MAC) ? x[tap]    : '0;
  assign mac_b = (state == MAC) ? coef[tap] : '0;
  assign mac_c = (state == MAC) ? acc       : '0;

  assign sample_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler with a
// Q2.14 combinational MAC model on mac_d.
module tb_fir_mac_scheduler;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        sample_ready;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [15:0] mac_c;
  logic [15:0] mac_d;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] mbSeq [4];

  fir_mac_scheduler #(
    .WORD_LENGTH  (16),
    .INTEGER_PART (2),
    .TAPS         (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_c        (mac_c),
    .mac_d        (mac_d),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  function automatic logic [15:0] macModel(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c
  );
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[29:14] + c;
  endfunction

  assign mac_d = macModel(mac_a, mac_b, mac_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic writeCoef(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  // Sends one sample, optionally pulsing a coef write during MAC
  task automatic pushSample(
    input  logic [15:0] d,
    input  logic        busyWr,
    output logic [15:0] res,
    output int          lat
  );
    @(negedge clk);
    checkEq("ready_before_push", 32'(sample_ready), 32'd1);
    sample_valid = 1'b1;
    sample_in    = d;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    sample_in = 16'hDEAD;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) mbSeq[lat-1] = mac_b;
      coef_we = 1'b0;
      if (busyWr && lat == 1) begin
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 16'h7FFF;
      end
      if (result_valid) break;
    end
    coef_we = 1'b0;
    res = result;
  endtask

  logic [15:0] res;
  int          lat;
  int          lastAcc;
  int          lowRun;
  int          nRes;
  int          nRv;
  logic        incr;

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_data    = '0;
    repeat (3) @(negedge clk);
    checkEq("rst_ready", 32'(sample_ready), 32'd1);
    checkEq("rst_result", 32'(result), 32'd0);
    checkEq("rst_rv", 32'(result_valid), 32'd0);
    reset = 1'b1;

    // single tap, unity gain
    writeCoef(2'd0, 16'h4000);
    pushSample(16'h1000, 1'b0, res, lat);
    checkEq("t2_latency", 32'(lat), 32'd5);
    checkEq("t2_result", 32'(res), 32'h1000);
    checkEq("t2_mb0", 32'(mbSeq[0]), 32'h4000);
    checkEq("t2_mb1", 32'(mbSeq[1]), 32'h0000);
    checkEq("t2_mb2", 32'(mbSeq[2]), 32'h0000);
    checkEq("t2_mb3", 32'(mbSeq[3]), 32'h0000);
    @(negedge clk);
    checkEq("t2_rv_low", 32'(result_valid), 32'd0);
    checkEq("t2_hold", 32'(result), 32'h1000);

    // async reset, no clock edge needed
    #2 reset = 1'b0;
    #1;
    checkEq("t1_result", 32'(result), 32'd0);
    checkEq("t1_rv", 32'(result_valid), 32'd0);
    checkEq("t1_ready", 32'(sample_ready), 32'd1);
    checkEq("t1_mac", {8'd0, 8'd0, mac_a | mac_b | mac_c}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // impulse response
    for (int i = 0; i < 4; i++) writeCoef(2'(i), 16'h2000);
    pushSample(16'h2000, 1'b0, res, lat);
    checkEq("t3_imp0", 32'(res), 32'h1000);
    for (int i = 1; i < 4; i++) begin
      pushSample(16'h0000, 1'b0, res, lat);
      checkEq("t3_imp", 32'(res), 32'h1000);
    end
    pushSample(16'h0000, 1'b0, res, lat);
    checkEq("t3_imp4", 32'(res), 32'h0000);

    // continuous sample_valid
    doReset();
    writeCoef(2'd0, 16'h4000);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 16'h0100;
    lastAcc = -1;
    lowRun  = 0;
    nRes    = 0;
    incr    = 1'b0;
    for (int c = 0; c < 31; c++) begin
      if (c > 0) @(negedge clk);
      if (incr) sample_in = sample_in + 16'd1;
      incr = 1'b0;
      if (result_valid) begin
        checkEq("bp_result", 32'(result), 32'h0100 + 32'(nRes));
        nRes++;
      end
      if (sample_ready) begin
        if (lastAcc >= 0) begin
          checkEq("bp_gap", 32'(c - lastAcc), 32'd6);
          checkEq("bp_low", 32'(lowRun), 32'd5);
        end
        lastAcc = c;
        lowRun  = 0;
        incr    = 1'b1;
      end else begin
        lowRun++;
      end
    end
    sample_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkEq("bp_nres", 32'(nRes), 32'd5);

    // coefficient write while busy
    doReset();
    writeCoef(2'd0, 16'h4000);
    pushSample(16'h0800, 1'b1, res, lat);
    checkEq("t5_cur", 32'(res), 32'h0800);
    pushSample(16'h0400, 1'b0, res, lat);
    checkEq("t5_next", 32'(res), 32'h0400);
    writeCoef(2'd0, 16'h7FFF);
    pushSample(16'h1000, 1'b0, res, lat);
    checkEq("t5_idle_wr", 32'(res), 32'h1FFF);

    // reset in the second MAC cycle
    doReset();
    writeCoef(2'd0, 16'h4000);
    writeCoef(2'd1, 16'h4000);
    pushSample(16'h2000, 1'b0, res, lat);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 16'h2000;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkEq("t6_busy", 32'(busy), 32'd0);
    checkEq("t6_mac", {16'd0, mac_a | mac_b | mac_c}, 32'd0);
    nRv = 0;
    repeat (6) begin
      @(negedge clk);
      if (result_valid) nRv++;
    end
    checkEq("t6_no_rv", 32'(nRv), 32'd0);
    reset = 1'b1;
    writeCoef(2'd0, 16'h4000);
    writeCoef(2'd1, 16'h4000);
    pushSample(16'h1000, 1'b0, res, lat);
    checkEq("t6_latency", 32'(lat), 32'd5);
    checkEq("t6_result", 32'(res), 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
